spike_feature_extract: RTL and testbench

Upstream stage of the decision-tree spike classifier. Watches the raw signed ADC sample stream for a negative-going threshold crossing and captures a fixed window of samples. It reduces the window to three features (trough, following peak, trough-to-peak time). It then presents those features serially, one per handshake, to the tree's `in_valid`/`ready`/`sample` input.

---
 rtl/spike_feature_extract.sv | 128 ++++++++++++
 tb/tb_spike_feature_extract.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spike_feature_extract.sv
// spike_feature_extract: detects negative threshold crossings on adc_sample, captures WINDOW samples, emits trough/peak/time features one per out_valid&ready handshake; busy/dropped status; FEXT_DROP_CNT_EN adds 8-bit saturating drop_count
module spike_feature_extract #(
  parameter int IN_WIDTH = 10,
  parameter int WINDOW = 32,
  parameter int FEATURES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                adc_valid,
  input  logic [IN_WIDTH-1:0] adc_sample,
  input  logic [IN_WIDTH-1:0] threshold,
  output logic                out_valid,
  input  logic                ready,
  output logic [IN_WIDTH-1:0] feature,
  output logic [1:0]          feature_index,
  output logic                busy,
  output logic                dropped
`ifdef FEXT_DROP_CNT_EN
  ,
  output logic [7:0]          drop_count
`endif
);
  localparam int TW = $clog2(WINDOW);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW - 1);
  localparam logic [1:0] IDX_LAST = 2'(FEATURES - 1);
  logic [1:0] state_q, state_d, idx_q, idx_d, feature_index_q, feature_index_d;
  logic prev_below_q, prev_below_d, out_valid_q, out_valid_d, busy_q, busy_d, dropped_q, dropped_d;
  logic signed [IN_WIDTH-1:0] min_q, min_d, max_q, max_d, s;
  logic [IN_WIDTH-1:0] feature_q, feature_d;
  logic [TW-1:0] t_q, t_d, t_min_q, t_min_d, t_max_q, t_max_d, t_diff;
  logic below, crossing;
  assign s = $signed(adc_sample);
  assign below = adc_valid && (s <= $signed(threshold));
  assign crossing = below && !prev_below_q;
  assign t_diff = t_max_d - t_min_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    t_d = t_q;
    min_d = min_q;
    max_d = max_q;
    t_min_d = t_min_q;
    t_max_d = t_max_q;
    prev_below_d = adc_valid ? below : prev_below_q;
    dropped_d = crossing && state_q != IDLE;
    if (state_q == IDLE && crossing) begin
      state_d = CAPTURE;
      min_d = s;
      max_d = s;
      t_min_d = '0;
      t_max_d = '0;
      t_d = TW'(1);
    end else if (state_q == CAPTURE && adc_valid) begin
      if (s < min_q) begin
        min_d = s;
        max_d = s;
        t_min_d = t_q;
        t_max_d = t_q;
      end else if (s > max_q) begin
        max_d = s;
        t_max_d = t_q;
      end
      t_d = t_q + TW'(1);
      if (t_q == T_LAST) begin
        state_d = EMIT;
        idx_d = '0;
      end
    end else if (state_q == EMIT && ready) begin
      idx_d = idx_q + 2'd1;
      state_d = idx_q == IDX_LAST ? IDLE : EMIT;
    end
    out_valid_d = state_d == EMIT;
    busy_d = state_d != IDLE;
    feature_index_d = out_valid_d ? idx_d : 2'd0;
    feature_d = !out_valid_d ? '0 :
                idx_d == 2'd0 ? min_d :
                idx_d == 2'd1 ? max_d :
                {{(IN_WIDTH - TW){1'b0}}, t_diff};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      t_q <= '0;
      min_q <= '0;
      max_q <= '0;
      t_min_q <= '0;
      t_max_q <= '0;
      prev_below_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      dropped_q <= 1'b0;
      feature_q <= '0;
      feature_index_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      t_q <= t_d;
      min_q <= min_d;
      max_q <= max_d;
      t_min_q <= t_min_d;
      t_max_q <= t_max_d;
      prev_below_q <= prev_below_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
      dropped_q <= dropped_d;
      feature_q <= feature_d;
      feature_index_q <= feature_index_d;
    end
  end
  assign out_valid = out_valid_q;
  assign feature = feature_q;
  assign feature_index = feature_index_q;
  assign busy = busy_q;
  assign dropped = dropped_q;
`ifdef FEXT_DROP_CNT_EN
  logic [7:0] drop_count_q, drop_count_d;
  assign drop_count_d = dropped_q && drop_count_q != 8'hff ? drop_count_q + 8'd1 : drop_count_q;
  always_ff @(posedge clk) begin
    if (reset) drop_count_q <= '0;
    else drop_count_q <= drop_count_d;
  end
  assign drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_spike_feature_extract.sv
// tb_spike_feature_extract: directed self-checking bench for spike_feature_extract with WINDOW=8
module tb_spike_feature_extract;
  logic clk = 1'b0;
  logic reset, adc_valid, ready, out_valid, busy, dropped;
  logic [9:0] adc_sample, threshold, feature;
  logic [1:0] feature_index;
`ifdef FEXT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  int checks = 0;
  int errors = 0;
  int basic [8] = '{-120, -200, -150, 50, 300, 100, 0, 0};
  int ties [8] = '{-150, -200, -200, 80, 80, 0, 0, 0};
  int drops [8] = '{-120, -200, -150, 50, 300, -150, 0, 0};
  spike_feature_extract #(.IN_WIDTH(10), .WINDOW(8), .FEATURES(3)) dut (
    .clk(clk),
    .reset(reset),
    .adc_valid(adc_valid),
    .adc_sample(adc_sample),
    .threshold(threshold),
    .out_valid(out_valid),
    .ready(ready),
    .feature(feature),
    .feature_index(feature_index),
    .busy(busy),
    .dropped(dropped)
`ifdef FEXT_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic step(input logic v, input int smp);
    adc_valid = v;
    adc_sample = 10'(smp);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic feat(input string tag, input int idx, input int val);
    chk({tag, " out_valid"}, 32'(out_valid), 1);
    chk({tag, " index"}, 32'(feature_index), idx);
    chk({tag, " feature"}, $signed(feature), val);
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " feature"}, $signed(feature), 0);
    chk({tag, " index"}, 32'(feature_index), 0);
    chk({tag, " dropped"}, 32'(dropped), 0);
  endtask
  initial begin
    reset = 1'b1;
    ready = 1'b1;
    threshold = 10'(-100);
    step(0, 0);
    step(0, 0);
    idle_chk("reset");
`ifdef FEXT_DROP_CNT_EN
    chk("reset drop_count", 32'(drop_count), 0);
`endif
    reset = 1'b0;
    step(1, 0);
    chk("pre busy", 32'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, basic[i]);
      if (i == 0) chk("basic busy rise", 32'(busy), 1);
      if (i < 7) chk("basic no early valid", 32'(out_valid), 0);
    end
    feat("basic f0", 0, -200);
    step(0, 0);
    feat("basic f1", 1, 300);
    step(0, 0);
    feat("basic f2", 2, 3);
    step(0, 0);
    idle_chk("basic done");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ready = 1'b0;
      step(1, basic[i]);
    end
    for (int i = 0; i < 5; i++) begin
      feat("bp hold", 0, -200);
      if (i < 4) step(0, 0);
    end
    ready = 1'b1;
    step(0, 0);
    feat("bp f1", 1, 300);
    step(0, 0);
    feat("bp f2", 2, 3);
    step(0, 0);
    idle_chk("bp done");
    for (int i = 0; i < 8; i++) begin
      step(1, ties[i]);
      if (i < 7) step(0, -500);
    end
    feat("ties f0", 0, -200);
    step(0, 0);
    feat("ties f1", 1, 80);
    step(0, 0);
    feat("ties f2", 2, 2);
    step(0, 0);
    idle_chk("ties done");
    for (int i = 0; i < 8; i++) begin
      step(1, drops[i]);
      if (i == 0) chk("trigger not dropped", 32'(dropped), 0);
      if (i == 5) chk("capture drop pulse", 32'(dropped), 1);
      if (i == 6) chk("capture drop ends", 32'(dropped), 0);
    end
    feat("drops f0", 0, -200);
    ready = 1'b0;
    step(1, -300);
    chk("emit drop pulse", 32'(dropped), 1);
    feat("drops hold", 0, -200);
    step(1, 0);
    chk("emit drop ends", 32'(dropped), 0);
    ready = 1'b1;
    step(1, 0);
    feat("drops f1", 1, 300);
    step(1, 0);
    feat("drops f2", 2, 3);
`ifdef FEXT_DROP_CNT_EN
    chk("drop_count two", 32'(drop_count), 2);
`endif
    step(1, -300);
    chk("transfer-cycle drop", 32'(dropped), 1);
    chk("transfer-cycle idle", 32'(busy), 0);
    step(1, -300);
    chk("no event after drop", 32'(busy), 0);
`ifdef FEXT_DROP_CNT_EN
    chk("drop_count three", 32'(drop_count), 3);
`endif
    reset = 1'b1;
    step(1, -300);
    idle_chk("low reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1, -300);
    chk("low no busy", 32'(busy), 0);
    chk("low no drop", 32'(dropped), 0);
    step(1, 0);
    step(1, -300);
    chk("low retrigger busy", 32'(busy), 1);
    for (int i = 0; i < 7; i++) step(1, 0);
    feat("low f0", 0, -300);
    step(0, 0);
    feat("low f1", 1, 0);
    step(0, 0);
    feat("low f2", 2, 1);
    step(0, 0);
    step(0, 0);
    idle_chk("low one event");
    step(1, 0);
    for (int i = 0; i < 4; i++) step(1, basic[i]);
    chk("mid capture busy", 32'(busy), 1);
    reset = 1'b1;
    step(1, basic[4]);
    idle_chk("capture reset");
`ifdef FEXT_DROP_CNT_EN
    chk("drop_count cleared", 32'(drop_count), 0);
`endif
    reset = 1'b0;
    for (int i = 5; i < 8; i++) step(1, basic[i]);
    for (int i = 0; i < 4; i++) step(0, 0);
    idle_chk("no stale capture");
    for (int i = 0; i < 8; i++) step(1, basic[i]);
    feat("er f0", 0, -200);
    step(0, 0);
    feat("er f1", 1, 300);
    reset = 1'b1;
    step(0, 0);
    idle_chk("emit reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0);
    idle_chk("no stale emit");
    step(1, 0);
    for (int i = 0; i < 8; i++) step(1, ties[i]);
    feat("recover f0", 0, -200);
    step(0, 0);
    feat("recover f1", 1, 80);
    step(0, 0);
    feat("recover f2", 2, 2);
    step(0, 0);
    idle_chk("recover done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
